// File: rtl/hyperram_test_sequencer.sv
// Write/read-back pattern tester for the HyperRAM controller request port.
// Optional build macro HYPERRAM_TEST_LOOP_EN: repeat passes while start is held, seed mixed with passCount.
module hyperram_test_sequencer #(
  parameter int unsigned NUM_WORDS = 64,
  parameter logic [21:0] BASE_ADDR = 22'h000000,
  parameter logic [31:0] SEED      = 32'hA5A5_0001,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        memoryClock,
  input  logic        reset,
  input  logic        start,
  output logic        memReq,
  output logic        memWrite,
  output logic [21:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic        memReady,
  input  logic        writeDone,
  input  logic        readDataValid,
  input  logic [31:0] readReg,
  output logic [6:0]  testStateCounter,
  output logic        testDone,
  output logic        testFail,
  output logic [1:0]  failCause,
  output logic [21:0] failAddress,
  output logic [31:0] failData,
  output logic [15:0] passCount
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_WR_WAIT  = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_DONE     = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);
  localparam logic [15:0]   LAST_IDX = 16'(NUM_WORDS - 1);

  state_t        state_q, state_d;
  logic [15:0]   idx_q, idx_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          req_q, req_d;
  logic          wr_q, wr_d;
  logic [21:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [1:0]    cause_q, cause_d;
  logic [21:0]   fail_addr_q, fail_addr_d;
  logic [31:0]   fail_data_q, fail_data_d;
  logic [15:0]   pass_q, pass_d;

  logic [21:0] cur_addr;
  logic [31:0] seed_eff;
  logic [31:0] pattern;
  logic        last_word;
  logic        timed_out;

  assign cur_addr  = BASE_ADDR + {5'd0, idx_q, 1'b0};
`ifdef HYPERRAM_TEST_LOOP_EN
  assign seed_eff  = SEED ^ {16'h0000, pass_q};
`else
  assign seed_eff  = SEED;
`endif
  assign pattern   = seed_eff ^ {idx_q, ~idx_q};
  assign last_word = (idx_q == LAST_IDX);
  assign timed_out = (to_cnt_q == TO_LIMIT);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    to_cnt_d    = to_cnt_q;
    req_d       = req_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done_d      = done_q;
    fail_d      = fail_q;
    cause_d     = cause_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    pass_d      = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d       = 16'd0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          cause_d     = 2'b00;
          fail_addr_d = 22'd0;
          fail_data_d = 32'd0;
          state_d     = S_WR_ISSUE;
        end
      end
      // Request fields are loaded once, then frozen until the controller accepts.
      S_WR_ISSUE: begin
        if (!req_q) begin
          req_d   = 1'b1;
          wr_d    = 1'b1;
          addr_d  = cur_addr;
          wdata_d = pattern;
        end else if (memReady) begin
          req_d    = 1'b0;
          wr_d     = 1'b0;
          to_cnt_d = '0;
          state_d  = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (writeDone) begin
          if (last_word) begin
            idx_d   = 16'd0;
            state_d = S_RD_ISSUE;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = S_WR_ISSUE;
          end
        end else if (timed_out) begin
          fail_d      = 1'b1;
          cause_d     = 2'b10;
          fail_addr_d = cur_addr;
          state_d     = S_FAIL;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_RD_ISSUE: begin
        if (!req_q) begin
          req_d  = 1'b1;
          wr_d   = 1'b0;
          addr_d = cur_addr;
        end else if (memReady) begin
          req_d    = 1'b0;
          to_cnt_d = '0;
          state_d  = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (readDataValid) begin
          if (readReg != pattern) begin
            fail_d      = 1'b1;
            cause_d     = 2'b01;
            fail_addr_d = cur_addr;
            fail_data_d = readReg;
            state_d     = S_FAIL;
          end else if (last_word) begin
            if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = S_RD_ISSUE;
          end
        end else if (timed_out) begin
          fail_d      = 1'b1;
          cause_d     = 2'b11;
          fail_addr_d = cur_addr;
          state_d     = S_FAIL;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_DONE: begin
`ifdef HYPERRAM_TEST_LOOP_EN
        if (start) begin
          idx_d   = 16'd0;
          done_d  = 1'b0;
          state_d = S_WR_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
`else
        if (!start) state_d = S_IDLE;
`endif
      end
      S_FAIL: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge memoryClock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 16'd0;
      to_cnt_q    <= '0;
      req_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 22'd0;
      wdata_q     <= 32'd0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      cause_q     <= 2'b00;
      fail_addr_q <= 22'd0;
      fail_data_q <= 32'd0;
      pass_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      to_cnt_q    <= to_cnt_d;
      req_q       <= req_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      cause_q     <= cause_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      pass_q      <= pass_d;
    end
  end

  assign memReq           = req_q;
  assign memWrite         = wr_q;
  assign memAddress       = addr_q;
  assign memWriteData     = wdata_q;
  assign testStateCounter = {state_q, idx_q[3:0]};
  assign testDone         = done_q;
  assign testFail         = fail_q;
  assign failCause        = cause_q;
  assign failAddress      = fail_addr_q;
  assign failData         = fail_data_q;
  assign passCount        = pass_q;

endmodule

// File: tb/tb_hyperram_test_sequencer.sv
// Directed bench for hyperram_test_sequencer: controller responder, request-stream model, literal pins.
module tb_hyperram_test_sequencer;

  localparam int          NW   = 4;
  localparam logic [21:0] BASE = 22'h000000;
  localparam logic [31:0] SEED = 32'hA5A5_0001;
  localparam int          TO   = 15;
`ifdef HYPERRAM_TEST_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic        memoryClock = 1'b0;
  logic        reset, start;
  logic        memReq, memWrite, memReady, writeDone, readDataValid;
  logic [21:0] memAddress, failAddress;
  logic [31:0] memWriteData, readReg, failData;
  logic [6:0]  testStateCounter;
  logic        testDone, testFail;
  logic [1:0]  failCause;
  logic [15:0] passCount;

  hyperram_test_sequencer #(
    .NUM_WORDS(NW), .BASE_ADDR(BASE), .SEED(SEED), .TIMEOUT(TO)
  ) dut (
    .memoryClock(memoryClock), .reset(reset), .start(start),
    .memReq(memReq), .memWrite(memWrite), .memAddress(memAddress),
    .memWriteData(memWriteData), .memReady(memReady), .writeDone(writeDone),
    .readDataValid(readDataValid), .readReg(readReg),
    .testStateCounter(testStateCounter), .testDone(testDone), .testFail(testFail),
    .failCause(failCause), .failAddress(failAddress), .failData(failData),
    .passCount(passCount)
  );

  always #5 memoryClock = ~memoryClock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Controller behaviour knobs (-1 = feature off)
  int bp_cycles, corrupt_word, drop_wr_word, drop_rd_word, slow_wr_word, slow_delay;
  bit late_pulse;
  logic [31:0] mem [int];

  function automatic int word_of(input logic [21:0] a);
    logic [21:0] off;
    off = a - BASE;
    return int'(off >> 1);
  endfunction

  function automatic logic [31:0] mem_rd(input int w);
    if (mem.exists(w)) return mem[w];
    return 32'd0;
  endfunction

  // Reference pattern computed straight from the word index and pass number
  function automatic logic [31:0] pat(input int w, input int pc);
    logic [15:0] i16, p16;
    i16 = 16'(w);
    p16 = LOOP_EN ? 16'(pc) : 16'd0;
    return SEED ^ {16'h0000, p16} ^ {i16, ~i16};
  endfunction

  // Ideal HyperRAM controller with fault injection
  initial begin : responder
    bit acc, acc_wr, pend_wr, drop;
    logic [21:0] acc_addr;
    logic [31:0] acc_data;
    int pend, pend_word, stall, w;
    acc = 0; acc_wr = 0; pend_wr = 0; acc_addr = '0; acc_data = '0;
    pend = -1; pend_word = 0; stall = 0;
    memReady = 0; writeDone = 0; readDataValid = 0; readReg = '0;
    forever begin
      @(posedge memoryClock); #1;
      writeDone = 0; readDataValid = 0;
      if (late_pulse) begin
        readDataValid = 1; readReg = 32'hDEAD_BEEF; late_pulse = 0;
      end
      if (reset) begin
        acc = 0; pend = -1; stall = 0;
      end
      if (acc) begin
        w = word_of(acc_addr);
        if (acc_wr) mem[w] = acc_data;
        drop = acc_wr ? (w == drop_wr_word) : (w == drop_rd_word);
        if (!drop) begin
          pend = (acc_wr && w == slow_wr_word) ? slow_delay : 0;
          pend_wr = acc_wr; pend_word = w;
        end
      end
      if (pend == 0) begin
        if (pend_wr) writeDone = 1;
        else begin
          readDataValid = 1;
          readReg = mem_rd(pend_word) ^ ((pend_word == corrupt_word) ? 32'd1 : 32'd0);
        end
        pend = -1;
      end else if (pend > 0) pend--;
      if (memReq && !reset) begin
        if (stall >= bp_cycles) memReady = 1;
        else begin memReady = 0; stall++; end
      end else memReady = 0;
      acc = memReq && memReady;
      if (acc) begin
        acc_wr = memWrite; acc_addr = memAddress; acc_data = memWriteData; stall = 0;
      end
    end
  end

  // Request-stream model: N writes then N reads per pass, in index order
  int exp_k, exp_pc, n_acc;
  bit prev_hold = 0;
  logic [54:0] prev_fields;
  bit exp_wr;
  int exp_w;

  always @(negedge memoryClock) begin
    if (reset) prev_hold = 0;
    else begin
      if (prev_hold) begin
        chk("req_held", memReq, 1'b1);
        chk("fields_held", {memWrite, memAddress, memWriteData}, prev_fields);
      end
      if (memReq && memReady) begin
        exp_wr = (exp_k < NW);
        exp_w  = exp_wr ? exp_k : exp_k - NW;
        chk("req_kind", memWrite, exp_wr);
        chk("req_addr", memAddress, BASE + 22'(2 * exp_w));
        if (exp_wr) chk("req_wdata", memWriteData, pat(exp_w, exp_pc));
        $display("txn %0d: %s word %0d addr=0x%06h data=0x%08h", n_acc,
                 memWrite ? "WR" : "RD", exp_w, memAddress, memWriteData);
        n_acc++; exp_k++;
        if (exp_k == 2 * NW) begin exp_k = 0; exp_pc++; end
      end
      prev_hold = memReq && !memReady;
      prev_fields = {memWrite, memAddress, memWriteData};
    end
  end

  task automatic do_reset();
    reset = 1; start = 0;
    repeat (2) @(posedge memoryClock);
    #1 reset = 0;
    exp_k = 0; exp_pc = 0; n_acc = 0;
    bp_cycles = 0; corrupt_word = -1; drop_wr_word = -1; drop_rd_word = -1;
    slow_wr_word = -1; slow_delay = 0; late_pulse = 0;
    mem.delete();
  endtask

  task automatic go();
    @(posedge memoryClock); #1 start = 1;
  endtask

  task automatic wait_end(input int limit);
    int c = 0;
    while (!(testDone || testFail) && c < limit) begin
      @(negedge memoryClock); c++;
    end
    chk("end_reached", testDone | testFail, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, {memReq, memWrite}, 2'b00);
    chk({tag, "_addr"}, memAddress, 22'd0);
    chk({tag, "_wdata"}, memWriteData, 32'd0);
    chk({tag, "_tsc"}, testStateCounter, 7'd0);
    chk({tag, "_flags"}, {testDone, testFail, failCause}, 4'd0);
    chk({tag, "_faddr"}, failAddress, 22'd0);
    chk({tag, "_fdata"}, failData, 32'd0);
    chk({tag, "_pass"}, passCount, 16'd0);
  endtask

  initial begin : main
    int cyc;
    reset = 1; start = 0;
    bp_cycles = 0; corrupt_word = -1; drop_wr_word = -1; drop_rd_word = -1;
    slow_wr_word = -1; slow_delay = 0; late_pulse = 0;
    exp_k = 0; exp_pc = 0; n_acc = 0;

    // Reset state
    do_reset();
    @(negedge memoryClock);
    chk_all_zero("reset");

    // Error-free pass with latency and cycle count
    go();
    @(posedge memoryClock); #1 chk("lat_edgeN", memReq, 1'b0);
    @(posedge memoryClock); #1 chk("lat_edgeN1", memReq, 1'b1);
    cyc = 1;
    while (!testDone && cyc < 200) begin
      @(posedge memoryClock); #1 cyc++;
    end
    chk("pass_cycles", cyc, 24);
    start = 0;
    chk("ok_tsc", testStateCounter, 7'h53);
    chk("ok_pass", passCount, 16'd1);
    chk("ok_fail", {testFail, failCause}, 3'b000);
    chk("ok_nacc", n_acc, 8);
    chk("ok_mem0", mem_rd(0), 32'hA5A5_FFFE);
    chk("ok_mem3", mem_rd(3), 32'hA5A6_FFFD);
    repeat (2) @(negedge memoryClock);
    chk("idle_state", testStateCounter[6:4], 3'd0);
    chk("done_sticky", testDone, 1'b1);

    // Data mismatch on word 2
    do_reset();
    corrupt_word = 2;
    go();
    wait_end(300);
    chk("mm_tsc", testStateCounter, 7'h62);
    chk("mm_cause", failCause, 2'b01);
    chk("mm_addr", failAddress, 22'd4);
    chk("mm_data", failData, 32'hA5A7_FFFD);
    chk("mm_flags", {testDone, testFail, passCount}, {2'b01, 16'd0});
    chk("mm_nacc", n_acc, 7);
    start = 0;

    // Backpressure: 10 stall cycles per request
    do_reset();
    bp_cycles = 10;
    go();
    wait_end(1000);
    chk("bp_flags", {testDone, testFail}, 2'b10);
    chk("bp_pass", passCount, 16'd1);
    chk("bp_nacc", n_acc, 8);
    start = 0;

    // Write timeout on word 1
    do_reset();
    drop_wr_word = 1;
    go();
    cyc = 0;
    do begin @(negedge memoryClock); cyc++; end
    while (!(memReq && memReady && memWrite && memAddress == 22'd2) && cyc < 200);
    chk("to_wr1_accept", {memReq, memReady, memAddress}, {2'b11, 22'd2});
    @(posedge memoryClock);
    cyc = 0;
    while (!testFail && cyc < 100) begin
      @(posedge memoryClock); #1 cyc++;
    end
    chk("to_cycles", cyc, 16);
    chk("to_cause", failCause, 2'b10);
    chk("to_addr", failAddress, 22'd2);
    chk("to_tsc", testStateCounter, 7'h61);
    start = 0;

    // Completion arriving on the last allowed cycle wins over the timeout
    do_reset();
    slow_wr_word = 1; slow_delay = 15;
    go();
    wait_end(300);
    chk("edge_flags", {testDone, testFail}, 2'b10);
    chk("edge_pass", passCount, 16'd1);
    start = 0;

    // Read timeout on word 2
    do_reset();
    drop_rd_word = 2;
    go();
    wait_end(300);
    chk("rto_cause", failCause, 2'b11);
    chk("rto_addr", failAddress, 22'd4);
    chk("rto_tsc", testStateCounter, 7'h62);
    start = 0;

    // Reset while waiting on read 3, followed by a stray completion
    do_reset();
    drop_rd_word = 3;
    go();
    cyc = 0;
    while (testStateCounter != 7'h43 && cyc < 200) begin
      @(negedge memoryClock); cyc++;
    end
    chk("rr_reached", testStateCounter, 7'h43);
    repeat (3) @(posedge memoryClock);
    #1 reset = 1; start = 0;
    @(posedge memoryClock); #1;
    chk("rr_req_low", memReq, 1'b0);
    chk("rr_idle", testStateCounter[6:4], 3'd0);
    reset = 0; late_pulse = 1;
    repeat (4) @(negedge memoryClock);
    chk_all_zero("rr");

`ifdef HYPERRAM_TEST_LOOP_EN
    // Continuous passes with the seed advanced by passCount
    do_reset();
    go();
    cyc = 0;
    while (passCount != 16'd2 && cyc < 500) begin
      @(negedge memoryClock); cyc++;
    end
    chk("loop_pass2", passCount, 16'd2);
    chk("loop_mem0_p2", mem_rd(0), 32'hA5A5_FFFF);
    while (passCount != 16'd3 && cyc < 1000) begin
      @(negedge memoryClock); cyc++;
    end
    chk("loop_pass3", passCount, 16'd3);
    chk("loop_done_pulse", testDone, 1'b1);
    start = 0;
    chk("loop_nacc", n_acc, 24);
`endif

    repeat (2) @(posedge memoryClock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
